// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key code convention, column
// reset pattern and key FSM encoding. The row*4+col code convention is shared
// with the display and game logic so a code can drive a display nibble directly.
package keypad_scanner_pkg;

    localparam int unsigned KEY_W    = 4;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_KEYS = 16;

    // Column 0 driven low out of reset.
    localparam logic [3:0] COL_RESET = 4'b1110;

    typedef enum logic {
        StIdle = 1'b0,
        StHeld = 1'b1
    } key_state_e;

    // Key code for a matrix position: row*4 + col.
    function automatic logic [KEY_W-1:0] key_code_of(input logic [1:0] row,
                                                     input logic [1:0] col);
        return {row, col};
    endfunction

    // True when exactly one key is set in the map.
    function automatic logic is_single(input logic [NUM_KEYS-1:0] map);
        return (map != '0) && ((map & (map - 1'b1)) == '0);
    endfunction

    // Index of the set key; only meaningful when is_single() holds.
    function automatic logic [KEY_W-1:0] key_index(input logic [NUM_KEYS-1:0] map);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (map[i]) idx = KEY_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a key map must be seen in DEBOUNCE_SCANS consecutive
// identical frames before it is copied to the stable map.
module keypad_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_end_i,
    input  logic [NUM_KEYS-1:0] frame_i,
    output logic [NUM_KEYS-1:0] stable_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Compare each completed frame with the last one and load once the run is long enough.
    always_comb begin
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (frame_end_i) begin
            prev_d = frame_i;
            if (frame_i == prev_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = CNT_W'(1);
            end
            // Reloading on every later matching frame is harmless and keeps this simple.
            if (cnt_d == CNT_MAX) stable_d = frame_i;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, samples the
// synchronised active-low rows into a 16-key frame, debounces whole frames and
// emits a one-cycle event with the row*4+col code of a newly pressed single key.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    logic [3:0]          rows_meta_q, rows_s;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick;
    logic [1:0]          col_q, col_d;
    logic [3:0]          col_out_q, col_out_d;
    logic [NUM_KEYS-1:0] frame_q, frame_d;
    logic                frame_end;
    logic [NUM_KEYS-1:0] stable;

    key_state_e          state_q, state_d;
    logic [KEY_W-1:0]    key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_down_q, key_down_d;

    // Two-flop synchroniser for the asynchronous keypad rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_meta_q <= 4'b1111;
            rows_s      <= 4'b1111;
        end else begin
            rows_meta_q <= row_in;
            rows_s      <= rows_meta_q;
        end
    end

    assign tick      = (div_q == DIV_MAX);
    assign frame_end = tick && (col_q == 2'd3);

    // Divider, column rotation and frame capture; rows settle SCAN_DIV-1 clocks before sampling.
    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        col_d     = col_q;
        col_out_d = col_out_q;
        frame_d   = frame_q;
        if (tick) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                frame_d[key_code_of(2'(r), col_q)] = ~rows_s[r];
            end
            col_d     = col_q + 2'd1;
            col_out_d = {col_out_q[2:0], col_out_q[3]};
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            col_q     <= '0;
            col_out_q <= COL_RESET;
            frame_q   <= '0;
        end else begin
            div_q     <= div_d;
            col_q     <= col_d;
            col_out_q <= col_out_d;
            frame_q   <= frame_d;
        end
    end

    // frame_d carries the column-3 bits captured on the frame-end tick.
    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_end_i(frame_end),
        .frame_i    (frame_d),
        .stable_o   (stable)
    );

    // Key FSM: report a lone key once, then wait for an empty map before re-arming.
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        unique case (state_q)
            StIdle: begin
                if (is_single(stable)) begin
                    key_code_d  = key_index(stable);
                    key_valid_d = 1'b1;
                    key_down_d  = 1'b1;
                    state_d     = StHeld;
                end
            end
            StHeld: begin
                if (stable == '0) begin
                    key_down_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Key FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16 clocks per frame).
// A behavioural keypad drives the rows from the column drive; key events are
// checked against a queue of expected codes.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned FRAME    = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys     = '0;
    logic        ovr_en   = 1'b0;
    logic [3:0]  ovr_rows = 4'hF;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc;
    logic [3:0]  exp_q[$];

    typedef struct {
        string       name;
        logic [15:0] keys;
        int unsigned frames;
        bit          push;
        logic [3:0]  code;
        bit          down;
    } phase_t;

    phase_t ph[$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    // Matrix model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
        if (ovr_en) row_in = ovr_rows;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next frame-end edge.
    task automatic to_frame_start();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % FRAME != 0);
    endtask

    // Scoreboard: every key_valid pulse must match the oldest expected code.
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got code %0d expected no event", key_code);
            end else begin
                check("event_code", 32'(key_code), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pats[4];
        logic [3:0] exp_col;

        // name, keys, frames, push event, code (event / expected held code), key_down
        ph.push_back('{"idle",       16'h0000, 2, 1'b0, 4'd0,  1'b0});
        ph.push_back('{"press9",     16'h0200, 5, 1'b1, 4'd9,  1'b1});
        ph.push_back('{"rel9",       16'h0000, 3, 1'b0, 4'd9,  1'b0});
        for (int i = 0; i < 3; i++) begin
            ph.push_back('{"bounce_on",  16'h0200, 1, 1'b0, 4'd9, 1'b0});
            ph.push_back('{"bounce_off", 16'h0000, 1, 1'b0, 4'd9, 1'b0});
        end
        ph.push_back('{"chord",      16'h0021, 4, 1'b0, 4'd9,  1'b0});
        ph.push_back('{"chord_rel5", 16'h0001, 3, 1'b1, 4'd0,  1'b1});
        ph.push_back('{"rel0",       16'h0000, 3, 1'b0, 4'd0,  1'b0});
        ph.push_back('{"hold3",      16'h0008, 3, 1'b1, 4'd3,  1'b1});
        ph.push_back('{"add12",      16'h1008, 4, 1'b0, 4'd3,  1'b1});
        ph.push_back('{"rel_both_1", 16'h0000, 1, 1'b0, 4'd3,  1'b1});
        ph.push_back('{"rel_both_2", 16'h0000, 2, 1'b0, 4'd3,  1'b0});
        ph.push_back('{"hold6",      16'h0040, 3, 1'b1, 4'd6,  1'b1});
        ph.push_back('{"swap10",     16'h0400, 3, 1'b0, 4'd6,  1'b1});
        ph.push_back('{"rel10",      16'h0000, 3, 1'b0, 4'd6,  1'b0});
        ph.push_back('{"press9b",    16'h0200, 3, 1'b1, 4'd9,  1'b1});

        pats[0] = 4'h0;
        pats[1] = 4'hA;
        pats[2] = 4'h5;
        pats[3] = 4'h3;

        // Reset held with rows toggling.
        #2 rst_n  = 1'b0;
        ovr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ovr_rows = pats[i];
            @(posedge clk);
            #1;
            check("rst_col_out", 32'(col_out), 32'(4'b1110));
            check("rst_key_valid", 32'(key_valid), 32'(1'b0));
            check("rst_key_down", 32'(key_down), 32'(1'b0));
        end
        check("rst_key_code", 32'(key_code), 32'(4'd0));

        @(negedge clk);
        rst_n  = 1'b1;
        ovr_en = 1'b0;
        #1;
        check("col_step0", 32'(col_out), 32'(4'b1110));
        for (int k = 1; k <= 4; k++) begin
            repeat (4) @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << (k % 4));
            check("col_step", 32'(col_out), 32'(exp_col));
        end

        // Table-driven phases, each starting on a frame boundary.
        foreach (ph[i]) begin
            keys = ph[i].keys;
            if (ph[i].push) exp_q.push_back(ph[i].code);
            for (int f = 0; f < int'(ph[i].frames); f++) to_frame_start();
            check({ph[i].name, "_pending"}, 32'(exp_q.size()), 32'd0);
            check({ph[i].name, "_key_down"}, 32'(key_down), 32'(ph[i].down));
            check({ph[i].name, "_key_code"}, 32'(key_code), 32'(ph[i].code));
        end

        // Asynchronous reset while key 9 is held.
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_col_out", 32'(col_out), 32'(4'b1110));
        check("mid_rst_key_valid", 32'(key_valid), 32'(1'b0));
        check("mid_rst_key_down", 32'(key_down), 32'(1'b0));
        check("mid_rst_key_code", 32'(key_code), 32'(4'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        to_frame_start();
        to_frame_start();
        check("post_rst_no_early_down", 32'(key_down), 32'(1'b0));
        check("post_rst_no_early_code", 32'(key_code), 32'(4'd0));
        exp_q.push_back(4'd9);
        to_frame_start();
        check("post_rst_pending", 32'(exp_q.size()), 32'd0);
        check("post_rst_key_down", 32'(key_down), 32'(1'b1));
        check("post_rst_key_code", 32'(key_code), 32'(4'd9));

        keys = '0;
        for (int f = 0; f < 3; f++) to_frame_start();
        check("final_key_down", 32'(key_down), 32'(1'b0));
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver, used for player input and score entry.
- Drives one active-low column of a 4x4 matrix keypad at a time, rotating at the same per-digit rate as the display mux, and samples the active-low rows.
- Debounces the resulting 16-key map and emits a single-cycle key event with a 4-bit code.
- The 4-bit code feeds the game FSM and can be looped straight into a display nibble.

Parameters:
- SCAN_DIV, 100_000, clocks per column slot. Legal range is >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full frames required before the stable map updates. Legal range is >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row_in  input  4  keypad rows, active-low (externally pulled up), asynchronous to clk
- col_out  output  4  column drive, active-low one-hot
- key_code  output  4  code of the last accepted key, index = row*4 + col
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_down  output  1  high while the accepted key (or any key after it) is held

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low. All state clears immediately on rst_n low:
  - col_out=4'b1110, key_code=0, key_valid=0, key_down=0
  - divider=0, column index=0, frame/stable maps=0, debounce count=0, FSM=IDLE
- Reset mid-scan or mid-press: any partial frame is discarded. After release, a still-held key is reported again after the full debounce time.
- Synchroniser: row_in passes through a 2-flop synchroniser, reset to 4'b1111. All logic uses the synchronised value rows_s.
- Divider: counts 0..SCAN_DIV-1 and wraps. tick=1 on the cycle the divider equals SCAN_DIV-1.
- On tick:
  - Sample ~rows_s into frame bits [r*4+c] for the current column c.
  - Then advance c to (c+1) mod 4 and set col_out = ~(1<<c_next).
  - Rows therefore settle for SCAN_DIV-1 cycles before each sample.
- Frame end is the tick with c=3. The completed frame is the 4 columns just sampled, including the column-3 bits captured that cycle.
- Debounce, evaluated at frame end:
  - If the frame equals the previous frame, increment a saturating count; otherwise set count=1.
  - When count reaches DEBOUNCE_SCANS, load the stable map; the same load repeats on later matching frames.
  - With DEBOUNCE_SCANS=1, every frame loads directly.
  - The previous-frame register always updates.
- Key FSM, evaluated every cycle on the stable map:
  - IDLE: if exactly one bit i is set, key_code<=i, key_valid<=1 for one cycle, key_down<=1, go to HELD. Zero bits or two or more bits (ghosting/chord) produce no event and the FSM stays in IDLE.
  - HELD: extra keys are ignored. When the stable map is all-zero, key_down<=0 and the FSM returns to IDLE. key_code holds its value.
- Latency: key_valid rises on the clock after the stable map loads. Worst case from a clean press is (DEBOUNCE_SCANS+1) frames + 3 clocks.
- A press/release shorter than DEBOUNCE_SCANS frames never changes the stable map, so no event is produced.
- Release and a new single press inside the same frame appear as one direct map change. The FSM is in HELD, so no event is produced until the map has been seen empty.

Decomposition:
- Shared package holds:
  - COL_RESET = 4'b1110
  - KEY_W = 4
  - FSM state encoding (IDLE=1'b0, HELD=1'b1)
  - the row*4+col code convention, shared with the display/game logic
- One sub-module, keypad_debounce: frame-compare counter plus stable-map register, 16-bit in/out with a frame_end strobe.
- Divider, column rotation, synchroniser and FSM stay in the top.

Test Plan:
- All tests use SCAN_DIV=4, DEBOUNCE_SCANS=2, so one frame = 16 clocks.
- Reset: hold rst_n low, toggle row_in -> col_out=1110, key_valid=0, key_down=0. Release -> col_out steps 1110, 1101, 1011, 0111, 1110 every 4 clocks.
- Clean press: key at row 2, col 1 (row_in[2]=0 only while col_out[1]=0) held for 5 frames -> exactly one key_valid pulse, key_code=4'd9, key_down=1. Release for 3 frames -> key_down=0 and no further pulse.
- Bounce: the same key pressed for 1 frame, released 1 frame, repeated 3 times -> no key_valid, key_down stays 0.
- Chord: keys 0 and 5 held for 4 frames -> no event. Release key 5 only -> one event with code 0.
- Held plus extra: hold key 3 (event, code 3), then add key 12 for 4 frames, then release both -> no second event; key_down falls only after both are released and stable.
- Async reset mid-press: assert rst_n during HELD -> outputs clear immediately. Deassert with the key still held -> a new event, code unchanged, after at least 2 frames.
